shake_sponge_ctrl: RTL and testbench

Sequencing controller for the Keccak-f[1600] sponge in SHAKE128/SHAKE256 mode. It accepts 64-bit message words and steers each into state lanes. It applies SHAKE padding, launches permutations, and then streams the requested number of output lanes. It sits between the host-side word streams and the state register/permutation core. It owns no state data, only lane indices and strobes.

---
 rtl/shake_sponge_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_shake_sponge_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake_sponge_ctrl.sv
// Lane/strobe sequencer for a SHAKE128/SHAKE256 Keccak-f[1600] sponge (absorb, pad, permute, squeeze).
// Optional macro SHAKE_CTRL_PERM_TIMEOUT_EN aborts a job whose permutation does not complete in time.
module shake_sponge_ctrl #(
  parameter int W            = 64,
  parameter int OUT_LEN_W    = 16,
  parameter int PERM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 empty_msg,
  input  logic [OUT_LEN_W-1:0] out_len,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 absorb_en,
  output logic                 pad_en,
  output logic [W-1:0]         pad_word,
  output logic [4:0]           lane_idx,
  output logic                 state_clr,
  output logic                 perm_start,
  input  logic                 perm_done,
  output logic                 sq_valid,
  input  logic                 sq_ready,
  output logic                 sq_last,
  output logic [10:0]          rate_bits,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [3:0] {
    IDLE, ABSORB, PERM_A, PAD, PAD_END, PERM_P, SQUEEZE, PERM_S, DONE
  } state_t;

  localparam logic [W-1:0]         PAD_FIRST = W'(8'h1F);
  localparam logic [W-1:0]         PAD_LAST  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]         PAD_BOTH  = PAD_LAST | PAD_FIRST;
  localparam logic [OUT_LEN_W-1:0] OCNT_ONE  = OUT_LEN_W'(1);

  if (W < 8) begin : g_bad_w
    $error("W must be at least 8");
  end
  if (PERM_TIMEOUT < 2) begin : g_bad_timeout
    $error("PERM_TIMEOUT must be at least 2");
  end

  state_t               state;
  logic                 rate21;
  logic                 pad_pend;
  logic [OUT_LEN_W-1:0] olen;
  logic [OUT_LEN_W-1:0] ocnt;
  logic [4:0]           rate_last;
  logic                 last_lane;
  logic                 sq_fire;

  // lane_idx doubles as the lane counter; only PAD_END points it somewhere else
  assign rate_last = rate21 ? 5'd20 : 5'd16;
  assign last_lane = (lane_idx == rate_last);
  assign absorb_en = in_valid & in_ready;
  assign sq_fire   = sq_valid & sq_ready;

`ifdef SHAKE_CTRL_PERM_TIMEOUT_EN
  localparam int          TW       = $clog2(PERM_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(PERM_TIMEOUT - 1);
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rate21     <= 1'b0;
      pad_pend   <= 1'b0;
      olen       <= '0;
      ocnt       <= '0;
      in_ready   <= 1'b0;
      pad_en     <= 1'b0;
      pad_word   <= '0;
      lane_idx   <= '0;
      state_clr  <= 1'b0;
      perm_start <= 1'b0;
      sq_valid   <= 1'b0;
      sq_last    <= 1'b0;
      rate_bits  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef SHAKE_CTRL_PERM_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      state_clr  <= 1'b0;
      perm_start <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pad_en     <= 1'b0;
      pad_word   <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode[1]) begin
              rate21    <= ~mode[0];
              olen      <= out_len;
              ocnt      <= '0;
              pad_pend  <= 1'b0;
              lane_idx  <= '0;
              state_clr <= 1'b1;
              busy      <= 1'b1;
              rate_bits <= mode[0] ? 11'd1088 : 11'd1344;
              if (empty_msg) begin
                state    <= PAD;
                pad_en   <= 1'b1;
                pad_word <= PAD_FIRST;
              end else begin
                state    <= ABSORB;
                in_ready <= 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        ABSORB: begin
          if (absorb_en) begin
            if (last_lane) begin
              state      <= PERM_A;
              in_ready   <= 1'b0;
              perm_start <= 1'b1;
              pad_pend   <= in_last;
            end else if (in_last) begin
              state    <= PAD;
              in_ready <= 1'b0;
              lane_idx <= lane_idx + 5'd1;
              pad_en   <= 1'b1;
              pad_word <= (lane_idx + 5'd1 == rate_last) ? PAD_BOTH : PAD_FIRST;
            end else begin
              lane_idx <= lane_idx + 5'd1;
            end
          end
        end
        PERM_A: begin
          if (perm_done) begin
            lane_idx <= '0;
            if (pad_pend) begin
              state    <= PAD;
              pad_pend <= 1'b0;
              pad_en   <= 1'b1;
              pad_word <= PAD_FIRST;
            end else begin
              state    <= ABSORB;
              in_ready <= 1'b1;
            end
          end
        end
        PAD: begin
          // a pad landing on the final lane already carries both pad bits
          if (last_lane) begin
            state      <= PERM_P;
            perm_start <= 1'b1;
          end else begin
            state    <= PAD_END;
            pad_en   <= 1'b1;
            pad_word <= PAD_LAST;
            lane_idx <= rate_last;
          end
        end
        PAD_END: begin
          state      <= PERM_P;
          perm_start <= 1'b1;
        end
        PERM_P: begin
          if (perm_done) begin
            lane_idx <= '0;
            ocnt     <= '0;
            if (olen == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= SQUEEZE;
              sq_valid <= 1'b1;
              sq_last  <= (olen == OCNT_ONE);
            end
          end
        end
        SQUEEZE: begin
          if (sq_fire) begin
            if (sq_last) begin
              state    <= DONE;
              done     <= 1'b1;
              sq_valid <= 1'b0;
              sq_last  <= 1'b0;
            end else begin
              ocnt <= ocnt + OCNT_ONE;
              if (last_lane) begin
                state      <= PERM_S;
                perm_start <= 1'b1;
                sq_valid   <= 1'b0;
                sq_last    <= 1'b0;
              end else begin
                lane_idx <= lane_idx + 5'd1;
                sq_last  <= ((ocnt + OCNT_ONE) == (olen - OCNT_ONE));
              end
            end
          end
        end
        PERM_S: begin
          if (perm_done) begin
            state    <= SQUEEZE;
            lane_idx <= '0;
            sq_valid <= 1'b1;
            sq_last  <= (ocnt == (olen - OCNT_ONE));
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rate_bits <= '0;
          lane_idx  <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
`ifdef SHAKE_CTRL_PERM_TIMEOUT_EN
      // an overdue permutation abandons the job without a done pulse
      if ((state == PERM_A || state == PERM_P || state == PERM_S) && !perm_done) begin
        if (tcnt == TMO_LAST) begin
          state     <= IDLE;
          err       <= 1'b1;
          busy      <= 1'b0;
          rate_bits <= '0;
          lane_idx  <= '0;
          pad_pend  <= 1'b0;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_shake_sponge_ctrl.sv
// Scoreboard bench for shake_sponge_ctrl: a job-level model queues expected strobe events, a monitor pops them.
`timescale 1ns/1ps
module tb_shake_sponge_ctrl;
  localparam int W   = 64;
  localparam int OLW = 16;

  localparam int K_CLR = 0, K_ABS = 1, K_PAD = 2, K_PERM = 3, K_SQ = 4, K_DONE = 5, K_ERR = 6;
  localparam logic [63:0] PAD_FIRST = 64'h0000_0000_0000_001F;
  localparam logic [63:0] PAD_LAST  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] PAD_BOTH  = 64'h8000_0000_0000_001F;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic           empty_msg = 1'b0;
  logic [OLW-1:0] out_len = '0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           in_ready, absorb_en, pad_en;
  logic [W-1:0]   pad_word;
  logic [4:0]     lane_idx;
  logic           state_clr, perm_start;
  logic           perm_done = 1'b0;
  logic           sq_valid;
  logic           sq_ready = 1'b0;
  logic           sq_last;
  logic [10:0]    rate_bits;
  logic           busy, done, err;

  always #5 clk = ~clk;

  shake_sponge_ctrl #(.W(W), .OUT_LEN_W(OLW), .PERM_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .empty_msg(empty_msg), .out_len(out_len),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready), .absorb_en(absorb_en),
    .pad_en(pad_en), .pad_word(pad_word), .lane_idx(lane_idx), .state_clr(state_clr),
    .perm_start(perm_start), .perm_done(perm_done), .sq_valid(sq_valid), .sq_ready(sq_ready),
    .sq_last(sq_last), .rate_bits(rate_bits), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int          kind;
    int          lane;
    logic [63:0] word;
    bit          last;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  exp_rate_bits = 0;

  function automatic void tally(input bit ok, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endfunction

  function automatic void push(input int k, input int l, input logic [63:0] w, input bit last);
    ev_t e;
    e.kind = k; e.lane = l; e.word = w; e.last = last;
    exp_q.push_back(e);
  endfunction

  // Whole-job event sequence derived from the sponge rules: r-lane blocks, pad10*1 with 0x1F domain bits.
  function automatic void model_job(input int r, input int n, input int len);
    int p;
    push(K_CLR, 0, '0, 1'b0);
    for (int i = 0; i < n; i++) begin
      push(K_ABS, i % r, '0, 1'b0);
      if (i % r == r - 1) push(K_PERM, 0, '0, 1'b0);
    end
    p = n % r;
    if (p == r - 1) push(K_PAD, p, PAD_BOTH, 1'b0);
    else begin
      push(K_PAD, p, PAD_FIRST, 1'b0);
      push(K_PAD, r - 1, PAD_LAST, 1'b0);
    end
    push(K_PERM, 0, '0, 1'b0);
    for (int j = 0; j < len; j++) begin
      push(K_SQ, j % r, '0, (j == len - 1));
      if (j % r == r - 1 && j != len - 1) push(K_PERM, 0, '0, 1'b0);
    end
    push(K_DONE, 0, '0, 1'b0);
  endfunction

  function automatic void check_ev(input int k, input int l, input logic [63:0] w, input bit last);
    ev_t e;
    if (exp_q.size() == 0) begin
      tally(1'b0, $sformatf("event_unexpected got kind=%0d lane=%0d word=%h last=%0d, expected none", k, l, w, last));
      return;
    end
    e = exp_q.pop_front();
    tally(e.kind == k && e.lane == l && e.word == w && e.last == last,
          $sformatf("event got kind=%0d lane=%0d word=%h last=%0d, expected kind=%0d lane=%0d word=%h last=%0d",
                    k, l, w, last, e.kind, e.lane, e.word, e.last));
  endfunction

  function automatic logic [89:0] all_outs();
    return {in_ready, absorb_en, pad_en, pad_word, lane_idx, state_clr, perm_start,
            sq_valid, sq_last, rate_bits, busy, done, err};
  endfunction

  // Monitor
  bit         mon_stall = 1'b0;
  logic [4:0] mon_stall_lane = '0;
  initial begin
    int act;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_stall = 1'b0;
        continue;
      end
      if (mon_stall && sq_valid)
        tally(lane_idx == mon_stall_lane,
              $sformatf("stall_lane got=%0d expected=%0d", lane_idx, mon_stall_lane));
      act = int'(absorb_en) + int'(pad_en) + int'(sq_valid && sq_ready);
      if (act != 0) tally(act == 1, $sformatf("strobe_exclusive got=%0d expected=1", act));
      if (state_clr) check_ev(K_CLR, 0, '0, 1'b0);
      if (absorb_en) check_ev(K_ABS, int'(lane_idx), '0, 1'b0);
      if (pad_en) check_ev(K_PAD, int'(lane_idx), pad_word, 1'b0);
      if (perm_start) check_ev(K_PERM, 0, '0, 1'b0);
      if (sq_valid && sq_ready) check_ev(K_SQ, int'(lane_idx), '0, sq_last);
      if (done) begin
        check_ev(K_DONE, 0, '0, 1'b0);
        tally(busy && int'(rate_bits) == exp_rate_bits,
              $sformatf("done_status got busy=%0d rate_bits=%0d expected busy=1 rate_bits=%0d",
                        busy, rate_bits, exp_rate_bits));
      end
      if (err) check_ev(K_ERR, 0, '0, 1'b0);
      mon_stall      = sq_valid && !sq_ready;
      mon_stall_lane = lane_idx;
    end
  end

  // Random squeeze back-pressure
  initial begin
    forever begin
      @(posedge clk); #1;
      sq_ready = ($urandom_range(2) != 0);
    end
  end

  // Permutation core stand-in: random latency, occasional stray done when idle
  initial begin
    bit pend;
    int cnt;
    pend = 1'b0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      perm_done = 1'b0;
      if (perm_start) begin
        pend = 1'b1;
        cnt  = $urandom_range(4);
      end else if (pend) begin
        if (cnt == 0) begin
          perm_done = 1'b1;
          pend      = 1'b0;
        end else cnt--;
      end else if ($urandom_range(15) == 0) begin
        perm_done = 1'b1;
      end
    end
  end

  task automatic launch(input logic [1:0] m, input int n, input int len);
    int r, sent, cyc;
    r             = (m == 2'b10) ? 21 : 17;
    exp_rate_bits = (m == 2'b10) ? 1344 : 1088;
    model_job(r, n, len);
    @(posedge clk); #1;
    start = 1'b1; mode = m; empty_msg = (n == 0); out_len = OLW'(len);
    @(posedge clk); #1;
    start = 1'b0; empty_msg = 1'b0;
    sent = 0; cyc = 0;
    while (sent < n && cyc < 2000) begin
      in_valid = ($urandom_range(3) != 0);
      in_last  = (sent == n - 1);
      start    = $urandom_range(1) != 0;
      mode     = 2'b01;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    if (cyc >= 2000) tally(1'b0, $sformatf("absorb_timeout got sent=%0d expected=%0d", sent, n));
  endtask

  task automatic finish_job(input string name);
    int c;
    c = 0;
    while (c < 4000) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
      c++;
    end
    tally(c < 4000, $sformatf("%s complete got pending=%0d busy=%0d expected pending=0 busy=0",
                              name, exp_q.size(), busy));
    tally(rate_bits == 11'd0 && lane_idx == 5'd0,
          $sformatf("%s idle_outputs got rate_bits=%0d lane=%0d expected 0/0", name, rate_bits, lane_idx));
    exp_q.delete();
  endtask

  task automatic bad_start(input logic [1:0] m);
    push(K_ERR, 0, '0, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; mode = m; out_len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    tally(exp_q.size() == 0 && !busy,
          $sformatf("bad_mode got pending=%0d busy=%0d expected pending=0 busy=0", exp_q.size(), busy));
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    tally(all_outs() == '0, $sformatf("reset_outputs got=%h expected=0", all_outs()));
    rst = 1'b0;

    launch(2'b10, 3, 2);   finish_job("s128_n3_l2");
    launch(2'b11, 16, 3);  finish_job("s256_n16");
    launch(2'b11, 17, 2);  finish_job("s256_n17");
    launch(2'b10, 0, 40);  finish_job("s128_empty_l40");
    bad_start(2'b01);
    bad_start(2'b00);
    launch(2'b11, 5, 4);   finish_job("after_err");
    launch(2'b11, 0, 0);   finish_job("s256_empty_l0");
    launch(2'b10, 21, 21); finish_job("s128_n21_l21");
    launch(2'b11, 34, 1);  finish_job("s256_n34_l1");

    // reset in the middle of squeezing
    launch(2'b10, 5, 60);
    c = 0;
    while (!sq_valid && c < 500) begin
      @(negedge clk);
      c++;
    end
    tally(c < 500, "reach_squeeze got timeout expected sq_valid");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tally(all_outs() == '0, $sformatf("midjob_reset got=%h expected=0", all_outs()));
    exp_q.delete();
    @(negedge clk);
    tally(!busy, $sformatf("post_reset_busy got=%0d expected=0", busy));
    launch(2'b10, 7, 9);   finish_job("after_reset");

    for (int k = 0; k < 8; k++) begin
      logic [1:0] m;
      int n, len;
      m   = ($urandom_range(1) != 0) ? 2'b10 : 2'b11;
      n   = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 45));
      len = int'($urandom_range(0, 45));
      launch(m, n, len);
      finish_job($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
